n64_cmd_tx: RTL and testbench
=============================

Name: n64_cmd_tx

Overview:
- Serializes one N64 controller command word onto the one-wire data line using the N64 quarter-slot bit encoding.
- Sits directly downstream of the frequency divider. The divider's slow square-wave output is set to 1 MHz (12 MHz / 12) and feeds tick_in; each rising edge of tick_in marks one 1 µs quarter-slot.
- Drives an open-drain enable for the bidirectional pad and reports busy/done to the poll controller above.

Parameters:
- NBITS, 8, command length in bits; legal range 1..64; transmitted MSB first.

Ports:
- clk_in  input  1  system clock (12 MHz).
- rstn  input  1  asynchronous active-low reset.
- tick_in  input  1  divided clock from the frequency divider, synchronous to clk_in; only its rising edge is used.
- start  input  1  single-cycle request; sampled only in IDLE.
- data_in  input  NBITS  command word; captured on the accepted start.
- line_oe  output  1  1 = pull data line low, 0 = release (pad pull-up gives high).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rstn). Assertion immediately forces line_oe=0, busy=0, done=0, state=IDLE, tick_q=0, counters=0. Applies mid-transfer too; no done pulse is produced.
- Edge detect: tick_q <= tick_in every cycle; tick_rise = tick_in & ~tick_q. A tick_in already high at reset release produces a rise on the first cycle.
- All outputs are registered and change only on clk_in rising edges.
- States: IDLE, ARM, BIT, STOP.
- IDLE:
  - line_oe=0, busy=0.
  - start=1 → capture data_in into the shift register, bit_cnt=0, q=0, go to ARM. busy=1 next cycle.
- ARM:
  - line_oe=0.
  - Waits for a tick_rise to align slots.
  - On tick_rise → BIT with q=0.
- BIT:
  - Quarter q (0..3) is the value applied from the cycle after the tick_rise that starts it.
  - Current bit is shreg MSB.
  - line_oe=1 for q=0. For q=1 and q=2, line_oe=1 if the bit is 0, else 0. For q=3, line_oe=0.
  - Bit 0 = LLLH; bit 1 = LHHH.
  - On tick_rise with q=3: shift left, bit_cnt+1. If bit_cnt was NBITS-1 → STOP with q=0, else q=0 on the next bit.
- STOP:
  - q=0 low; q=1 and q=2 released (LHH).
  - On tick_rise with q=2 → IDLE: done=1 for one cycle, busy=0 in the same cycle.
- Timing: tick_rise count from the accepted start to done = 1 + 4·NBITS + 3 (36 for NBITS=8).
- start while busy: ignored; data_in changes while busy are ignored.
- start in the same cycle as the done pulse: accepted, since the state is IDLE that cycle.
- tick_in stalled: the block waits indefinitely.
- Counter widths: bit_cnt is $clog2(NBITS+1) bits; q is 2 bits.

Optional Feature:
- Macro: N64_CMD_TX_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state → next cycle line_oe=0, busy=0, state=IDLE, no done pulse.
  - abort has priority over tick_rise and start in the same cycle.
  - abort in IDLE has no effect.
- Undefined: no abort port; a transfer always runs to completion or until reset.

Test Plan:
- Reset: rstn=0 with start=1 and tick_in toggling → line_oe=0, busy=0, done=0 throughout. Release rstn → still idle until start.
- NBITS=8, data_in=8'h01, tick_in from a 12:1 divider:
  - line_oe per quarter = LLLH ×7, then LHHH, then LHH stop.
  - done exactly 1 cycle, one clk after the 36th tick_rise.
- data_in=8'hFF → LHHH ×8 + LHH. data_in=8'h00 → LLLH ×8 + LHH. busy=1 for the whole interval in both cases.
- start pulsed again mid-transfer with data_in=8'hAA → waveform still matches the originally captured word, and only one done pulse is seen.
- rstn pulsed low during a low quarter of bit 3 → line_oe=0 within the same cycle (asynchronous). A new start with 8'h01 then produces a correct full waveform.
- tick_in held high before and through start → ARM waits; BIT begins only after tick_in falls and rises again.
- With N64_CMD_TX_ABORT_EN: abort during bit 2 → line_oe=0 and busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/n64_cmd_tx_if.sv
// Command handshake between the poll controller and the N64 command serializer.
// Carries the start request and command word down, busy/done status back up.
interface n64_cmd_tx_if #(
  parameter int unsigned NBITS = 8
);
  logic             start;
  logic [NBITS-1:0] data_in;
  logic             busy;
  logic             done;

  modport master (output start, output data_in, input busy, input done);
  modport slave  (input start, input data_in, output busy, output done);
endinterface

// File: rtl/n64_cmd_tx.sv
// N64 one-wire command serializer: quarter-slot encoding (0 = LLLH, 1 = LHHH, stop = LHH).
// Optional N64_CMD_TX_ABORT_EN adds an abort input that returns any transfer to idle.
module n64_cmd_tx #(
  parameter int unsigned NBITS = 8
) (
  input  logic            clk_in,
  input  logic            rstn,
  input  logic            tick_in,
`ifdef N64_CMD_TX_ABORT_EN
  input  logic            abort,
`endif
  n64_cmd_tx_if.slave     bus,
  output logic            line_oe
);

  typedef enum logic [1:0] {IDLE, ARM, BIT, STOP} state_t;

  localparam int unsigned   CW   = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  state_t            state, state_n;
  logic [NBITS-1:0]  shreg, shreg_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [1:0]        q, q_n;
  logic              tick_q;
  logic              tick_rise;
  logic              oe_n;
  logic              done_n;
  logic              kill;

  assign tick_rise = tick_in & ~tick_q;

`ifdef N64_CMD_TX_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    q_n       = q;
    done_n    = 1'b0;
    if (kill && (state != IDLE)) begin
      state_n = IDLE;
      q_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg_n   = bus.data_in;
            bit_cnt_n = '0;
            q_n       = '0;
            state_n   = ARM;
          end
        end
        ARM: begin
          if (tick_rise) begin
            state_n = BIT;
            q_n     = '0;
          end
        end
        BIT: begin
          if (tick_rise) begin
            if (q == 2'd3) begin
              shreg_n   = shreg << 1;
              bit_cnt_n = bit_cnt + 1'b1;
              q_n       = '0;
              if (bit_cnt == LAST) state_n = STOP;
            end else begin
              q_n = q + 2'd1;
            end
          end
        end
        STOP: begin
          if (tick_rise) begin
            if (q == 2'd2) begin
              state_n = IDLE;
              q_n     = '0;
              done_n  = 1'b1;
            end else begin
              q_n = q + 2'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Line level is decoded from the next state so it is registered alongside it.
    oe_n = 1'b0;
    case (state_n)
      BIT:     oe_n = (q_n == 2'd0) | ((q_n != 2'd3) & ~shreg_n[NBITS-1]);
      STOP:    oe_n = (q_n == 2'd0);
      default: oe_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      q        <= '0;
      tick_q   <= 1'b0;
      line_oe  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      q        <= q_n;
      tick_q   <= tick_in;
      line_oe  <= oe_n;
      bus.busy <= (state_n != IDLE);
      bus.done <= done_n;
    end
  end

endmodule

// File: tb/tb_n64_cmd_tx.sv
// Scoreboard bench for n64_cmd_tx: expected quarter levels are queued at start and
// popped mid-quarter; busy/done are checked every cycle.
module tb_n64_cmd_tx;
  localparam int unsigned NBITS = 8;
  localparam int          QN    = 4 * NBITS + 3;

  logic clk_in = 1'b0;
  logic rstn;
  logic tick_in;
  logic line_oe;
`ifdef N64_CMD_TX_ABORT_EN
  logic abort;
`endif

  n64_cmd_tx_if #(.NBITS(NBITS)) bus ();

  n64_cmd_tx #(.NBITS(NBITS)) dut (
    .clk_in  (clk_in),
    .rstn    (rstn),
    .tick_in (tick_in),
`ifdef N64_CMD_TX_ABORT_EN
    .abort   (abort),
`endif
    .bus     (bus),
    .line_oe (line_oe)
  );

  always #5 clk_in = ~clk_in;

  int   n_checks;
  int   n_pass;
  bit   lvl_q[$];
  bit   active;
  bit   accept_pend;
  bit   tq;
  bit   tick_hold;
  bit   chain_en;
  logic [NBITS-1:0] chain_data;
  int   rises;
  int   since;
  int   div;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // line_oe=1 means the line is pulled low.
  task automatic push_word(input logic [NBITS-1:0] w);
    for (int i = NBITS - 1; i >= 0; i--) begin
      lvl_q.push_back(1'b1);
      lvl_q.push_back(!w[i]);
      lvl_q.push_back(!w[i]);
      lvl_q.push_back(1'b0);
    end
    lvl_q.push_back(1'b1);
    lvl_q.push_back(1'b0);
    lvl_q.push_back(1'b0);
  endtask

  task automatic step(input logic s, input logic [NBITS-1:0] d);
    logic             rise;
    logic             exp;
    bit               done_now;
    logic             ls;
    logic [NBITS-1:0] ld;
    @(negedge clk_in);
    done_now = 1'b0;
    ls = s;
    ld = d;
    if (!rstn) begin
      rise = 1'b0;
      tq   = 1'b0;
    end else begin
      rise = tick_in & ~tq;
      tq   = tick_in;
    end

    if (accept_pend) begin
      accept_pend = 1'b0;
      active      = 1'b1;
      rises       = 0;
      since       = 0;
      check("busy_start", bus.busy, 1);
      check("oe_arm", line_oe, 0);
    end else if (active) begin
      if (rise) begin
        rises++;
        since = 0;
      end else begin
        since++;
      end
      if (rises == 0) check("oe_arm", line_oe, 0);
      if (rises >= 1 && rises <= QN && since == 3) begin
        check("lvl_avail", lvl_q.size() > 0, 1);
        if (lvl_q.size() > 0) begin
          exp = lvl_q.pop_front();
          check("line_oe", line_oe, exp);
        end
      end
      if (rises == QN + 1) begin
        check("done", bus.done, 1);
        check("busy_end", bus.busy, 0);
        check("oe_end", line_oe, 0);
        active   = 1'b0;
        done_now = 1'b1;
      end else begin
        check("busy", bus.busy, 1);
        check("done_early", bus.done, 0);
      end
    end else begin
      check("idle_done", bus.done, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_oe", line_oe, 0);
    end

    if (chain_en && done_now) begin
      ls       = 1'b1;
      ld       = chain_data;
      chain_en = 1'b0;
    end
    if (tick_hold) begin
      tick_in = 1'b1;
    end else begin
      div     = (div + 1) % 12;
      tick_in = (div < 6);
    end
    bus.start   = ls;
    bus.data_in = ld;
    if (ls && rstn && !active && !accept_pend) begin
      accept_pend = 1'b1;
      push_word(ld);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((active || accept_pend) && n < budget) begin
      step(1'b0, '0);
      n++;
    end
    check("xfer_timeout", active || accept_pend, 0);
  endtask

  task automatic wait_pos(input int r, input int s, input string tag);
    int n;
    n = 0;
    while (!(active && rises == r && since == s) && n < 2000) begin
      step(1'b0, '0);
      n++;
    end
    check(tag, n < 2000, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    active = 0; accept_pend = 0; tq = 0; tick_hold = 0; chain_en = 0;
    rises = 0; since = 0; div = 0; chain_data = '0;
    rstn = 1'b0; tick_in = 1'b0; bus.start = 1'b1; bus.data_in = 8'hFF;
`ifdef N64_CMD_TX_ABORT_EN
    abort = 1'b0;
`endif

    // Held in reset with start high and tick toggling.
    repeat (20) step(1'b1, 8'hFF);
    step(1'b0, '0);
    rstn = 1'b1;
    repeat (15) step(1'b0, '0);

    step(1'b1, 8'h01);
    wait_idle(1000);
    repeat (5) step(1'b0, '0);

    // 8'hFF then 8'h00 started in the done cycle.
    chain_en   = 1'b1;
    chain_data = 8'h00;
    step(1'b1, 8'hFF);
    wait_idle(2000);
    repeat (5) step(1'b0, '0);

    // Start and new data while busy must be ignored.
    step(1'b1, 8'h3C);
    repeat (100) step(1'b0, 8'h55);
    step(1'b1, 8'hAA);
    wait_idle(1000);
    repeat (5) step(1'b0, '0);

    // Asynchronous reset during the low first quarter of bit 3.
    step(1'b1, 8'h01);
    wait_pos(13, 2, "reach_bit3");
    check("oe_bit3_low", line_oe, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_oe", line_oe, 0);
    check("async_busy", bus.busy, 0);
    check("async_done", bus.done, 0);
    active = 0; accept_pend = 0; lvl_q.delete();
    repeat (3) step(1'b0, '0);
    rstn = 1'b1;
    repeat (5) step(1'b0, '0);
    step(1'b1, 8'h01);
    wait_idle(1000);
    repeat (5) step(1'b0, '0);

    // tick_in held high across start: ARM must wait for a fresh rise.
    tick_hold = 1'b1;
    repeat (20) step(1'b0, '0);
    step(1'b1, 8'hC3);
    repeat (40) step(1'b0, '0);
    tick_hold = 1'b0;
    div = 5;
    wait_idle(1000);
    repeat (5) step(1'b0, '0);

`ifdef N64_CMD_TX_ABORT_EN
    step(1'b1, 8'h01);
    wait_pos(9, 4, "reach_bit2");
    abort = 1'b1;
    active = 0; lvl_q.delete();
    step(1'b0, '0);
    abort = 1'b0;
    repeat (30) step(1'b0, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
